// File: rtl/uart_rx_core_param.sv
`default_nettype none
// =============================================================================
// Module : uart_rx_core_param
// Brief  : UART receiver with 3-sample majority vote and parity/stop checks.
// Rev    : 1.0 - initial release
// =============================================================================
module uart_rx_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q,       state_d;
    logic [PRESCALE_W-1:0] edge_q,        edge_d;
    logic [BIT_W-1:0]      bit_q,         bit_d;
    logic [2:0]            samp_q,        samp_d;
    logic [DATA_WIDTH-1:0] shift_q,       shift_d;
    logic [PRESCALE_W-1:0] cfg_p_q,       cfg_p_d;
    logic                  cfg_par_en_q,  cfg_par_en_d;
    logic                  cfg_par_typ_q, cfg_par_typ_d;
    logic                  cfg_stop2_q,   cfg_stop2_d;
    logic                  par_fail_q,    par_fail_d;
    logic [DATA_WIDTH-1:0] p_data_q,      p_data_d;
    logic                  valid_q,       valid_d;
    logic                  par_err_q,     par_err_d;
    logic                  stp_err_q,     stp_err_d;
    logic                  busy_q;

    logic [PRESCALE_W-1:0] w_p_even;
    logic [PRESCALE_W-1:0] w_p_eff;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_dec;
    logic                  w_end;
    logic                  w_maj;
    logic                  done;
    logic                  stp_bad;

    // Odd prescale values are rounded down; anything below 8 is clamped.
    assign w_p_even = prescale & ~ONE_P;
    assign w_p_eff  = (w_p_even < MIN_P) ? MIN_P : w_p_even;
    assign w_half   = cfg_p_q >> 1;
    assign w_dec    = (edge_q == w_half + PRESCALE_W'(2));
    assign w_end    = (edge_q == cfg_p_q - ONE_P);
    assign w_maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                      (samp_q[1] & samp_q[2]);

    always_comb begin
        state_d       = state_q;
        edge_d        = w_end ? '0 : edge_q + ONE_P;
        bit_d         = bit_q;
        samp_d        = samp_q;
        shift_d       = shift_q;
        cfg_p_d       = cfg_p_q;
        cfg_par_en_d  = cfg_par_en_q;
        cfg_par_typ_d = cfg_par_typ_q;
        cfg_stop2_d   = cfg_stop2_q;
        par_fail_d    = par_fail_q;
        p_data_d      = p_data_q;
        valid_d       = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        done          = 1'b0;
        stp_bad       = 1'b0;

        if (edge_q == w_half - ONE_P) samp_d[0] = rx_in;
        if (edge_q == w_half)         samp_d[1] = rx_in;
        if (edge_q == w_half + ONE_P) samp_d[2] = rx_in;

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                // The detecting cycle counts as edge 0 of the start bit.
                if (!rx_in) begin
                    state_d       = S_START;
                    edge_d        = ONE_P;
                    bit_d         = '0;
                    par_fail_d    = 1'b0;
                    cfg_p_d       = w_p_eff;
                    cfg_par_en_d  = par_en;
                    cfg_par_typ_d = par_typ;
                    cfg_stop2_d   = stop_bits;
                end
            end
            S_START: begin
                if (w_dec && w_maj) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (w_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (w_dec) shift_d = {w_maj, shift_q[DATA_WIDTH-1:1]};
                if (w_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = cfg_par_en_q ? S_PARITY : S_STOP1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_dec && (w_maj != ((^shift_q) ^ cfg_par_typ_q))) par_fail_d = 1'b1;
                if (w_end) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (w_end) state_d = S_STOP2;
                if (w_dec) begin
                    if (!w_maj) begin
                        done    = 1'b1;
                        stp_bad = 1'b1;
                    end else if (!cfg_stop2_q) begin
                        done = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_dec) begin
                    done    = 1'b1;
                    stp_bad = !w_maj;
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
            end
        endcase

        // A parity failure is held until the frame ends so the receiver stays frame-aligned.
        if (done) begin
            state_d    = S_IDLE;
            edge_d     = '0;
            par_fail_d = 1'b0;
            if (!par_fail_q && !stp_bad) begin
                valid_d  = 1'b1;
                p_data_d = shift_q;
            end else begin
                par_err_d = par_fail_q;
                stp_err_d = stp_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            edge_q        <= '0;
            bit_q         <= '0;
            samp_q        <= '0;
            shift_q       <= '0;
            cfg_p_q       <= MIN_P;
            cfg_par_en_q  <= 1'b0;
            cfg_par_typ_q <= 1'b0;
            cfg_stop2_q   <= 1'b0;
            par_fail_q    <= 1'b0;
            p_data_q      <= '0;
            valid_q       <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_q        <= edge_d;
            bit_q         <= bit_d;
            samp_q        <= samp_d;
            shift_q       <= shift_d;
            cfg_p_q       <= cfg_p_d;
            cfg_par_en_q  <= cfg_par_en_d;
            cfg_par_typ_q <= cfg_par_typ_d;
            cfg_stop2_q   <= cfg_stop2_d;
            par_fail_q    <= par_fail_d;
            p_data_q      <= p_data_d;
            valid_q       <= valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core_param.sv
`default_nettype none
// =============================================================================
// Module : tb_uart_rx_core_param
// Brief  : Directed bench for uart_rx_core_param; pulses are logged with cycle stamps.
// Rev    : 1.0 - initial release
// =============================================================================
module tb_uart_rx_core_param;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic          stop_bits;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            dv_cyc[$];
    logic [DW-1:0] dv_dat[$];
    int            pe_cyc[$];
    int            se_cyc[$];

    uart_rx_core_param #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop_bits  (stop_bits),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(p_data);
        end
        if (par_err) pe_cyc.push_back(cyc);
        if (stp_err) se_cyc.push_back(cyc);
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_in = v;
        wait_cyc(n);
    endtask

    task automatic clear_log();
        dv_cyc.delete();
        dv_dat.delete();
        pe_cyc.delete();
        se_cyc.delete();
    endtask

    // Start bit is edge 0 at the first posedge after c_s; a bit index S
    // decided at edge P/2+2 shows its pulse at cyc == c_s + S*P + P/2 + 3.
    task automatic send_frame(input int p, input logic [DW-1:0] d, input bit has_par,
                              input bit par_bit, input bit s1, input bit has_s2,
                              input bit s2, input int spike_bit, output int c_s);
        c_s = cyc;
        drive(1'b0, p);
        for (int i = 0; i < DW; i++) begin
            if (i == spike_bit) begin
                drive(d[i], p / 2);
                drive(~d[i], 1);
                drive(d[i], p - p / 2 - 1);
            end else begin
                drive(d[i], p);
            end
        end
        if (has_par) drive(par_bit, p);
        drive(s1, p);
        if (has_s2) drive(s2, p);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_in = 1'b1; prescale = 6'd8;
        par_en = 1'b0; par_typ = 1'b0; stop_bits = 1'b0;
        wait_cyc(3);
        n_vec++; if (p_data !== 8'h00) begin n_err++; $display("FAIL reset_p_data got %h want 00", p_data); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL reset_par_err got %b want 0", par_err); end
        n_vec++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL reset_stp_err got %b want 0", stp_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        prescale = 6'd8; par_en = 1'b0; stop_bits = 1'b0;
        clear_log();
        send_frame(8, 8'hA5, 0, 0, 1, 0, 1, -1, c1);
        send_frame(8, 8'hA5, 0, 0, 1, 0, 1, -1, c2);
        wait_cyc(16);
        n_vec++; if (dv_cyc.size() !== 2) begin n_err++; $display("FAIL b2b_dv_count got %0d want 2", dv_cyc.size()); end
        n_vec++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== c1 + 79) begin n_err++; $display("FAIL b2b_dv0_cycle got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, c1 + 79); end
        n_vec++; if (((dv_cyc.size() > 1) ? dv_cyc[1] : -1) !== c2 + 79) begin n_err++; $display("FAIL b2b_dv1_cycle got %0d want %0d", (dv_cyc.size() > 1) ? dv_cyc[1] : -1, c2 + 79); end
        n_vec++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'h00) !== 8'hA5) begin n_err++; $display("FAIL b2b_data0 got %h want a5", (dv_dat.size() > 0) ? dv_dat[0] : 8'h00); end
        n_vec++; if (((dv_dat.size() > 1) ? dv_dat[1] : 8'h00) !== 8'hA5) begin n_err++; $display("FAIL b2b_data1 got %h want a5", (dv_dat.size() > 1) ? dv_dat[1] : 8'h00); end
        n_vec++; if (pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL b2b_err_pulses got %0d want 0", pe_cyc.size() + se_cyc.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_parity();
        int c1;
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0; stop_bits = 1'b0;
        clear_log();
        // 0x3C has four ones: even parity bit should be 0, drive 1.
        send_frame(16, 8'h3C, 1, 1, 1, 0, 1, -1, c1);
        wait_cyc(8);
        n_vec++; if (pe_cyc.size() !== 1) begin n_err++; $display("FAIL par_bad_pe_count got %0d want 1", pe_cyc.size()); end
        n_vec++; if (((pe_cyc.size() > 0) ? pe_cyc[0] : -1) !== c1 + 171) begin n_err++; $display("FAIL par_bad_pe_cycle got %0d want %0d", (pe_cyc.size() > 0) ? pe_cyc[0] : -1, c1 + 171); end
        n_vec++; if (dv_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL par_bad_other_pulses got %0d want 0", dv_cyc.size() + se_cyc.size()); end
        n_vec++; if (p_data !== 8'hA5) begin n_err++; $display("FAIL par_bad_p_data_held got %h want a5", p_data); end
        clear_log();
        send_frame(16, 8'h81, 1, 0, 1, 0, 1, -1, c1);
        wait_cyc(8);
        n_vec++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== c1 + 171) begin n_err++; $display("FAIL par_good_dv_cycle got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, c1 + 171); end
        n_vec++; if (p_data !== 8'h81) begin n_err++; $display("FAIL par_good_p_data got %h want 81", p_data); end
        n_vec++; if (pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL par_good_err_pulses got %0d want 0", pe_cyc.size() + se_cyc.size()); end
        // Odd parity: 0x07 has three ones, so the parity bit is 0.
        par_typ = 1'b1;
        clear_log();
        send_frame(16, 8'h07, 1, 0, 1, 0, 1, -1, c1);
        wait_cyc(8);
        n_vec++; if (dv_cyc.size() !== 1 || p_data !== 8'h07) begin n_err++; $display("FAIL par_odd_good got count %0d data %h want 1 07", dv_cyc.size(), p_data); end
        n_vec++; if (pe_cyc.size() !== 0) begin n_err++; $display("FAIL par_odd_pe got %0d want 0", pe_cyc.size()); end
        par_en = 1'b0; par_typ = 1'b0;
    endtask

    task automatic test_glitch();
        prescale = 6'd8;
        clear_log();
        rx_in = 1'b0;
        wait_cyc(2);
        rx_in = 1'b1;
        wait_cyc(4);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_before got %b want 1", busy); end
        wait_cyc(1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_after got %b want 0", busy); end
        wait_cyc(16);
        n_vec++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d want 0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
    endtask

    task automatic test_stop();
        int c1;
        prescale = 6'd8; par_en = 1'b0; stop_bits = 1'b1;
        clear_log();
        send_frame(8, 8'h55, 0, 0, 1, 1, 0, -1, c1);
        wait_cyc(24);
        n_vec++; if (((se_cyc.size() == 1) ? se_cyc[0] : -1) !== c1 + 87) begin n_err++; $display("FAIL stop2_se_cycle got %0d want %0d", (se_cyc.size() == 1) ? se_cyc[0] : -1, c1 + 87); end
        n_vec++; if (dv_cyc.size() + pe_cyc.size() !== 0) begin n_err++; $display("FAIL stop2_other_pulses got %0d want 0", dv_cyc.size() + pe_cyc.size()); end
        n_vec++; if (p_data !== 8'h07) begin n_err++; $display("FAIL stop2_p_data_held got %h want 07", p_data); end
        clear_log();
        send_frame(8, 8'h55, 0, 0, 0, 1, 1, -1, c1);
        wait_cyc(24);
        n_vec++; if (((se_cyc.size() == 1) ? se_cyc[0] : -1) !== c1 + 79) begin n_err++; $display("FAIL stop1_se_cycle got %0d want %0d", (se_cyc.size() == 1) ? se_cyc[0] : -1, c1 + 79); end
        n_vec++; if (dv_cyc.size() + pe_cyc.size() !== 0) begin n_err++; $display("FAIL stop1_other_pulses got %0d want 0", dv_cyc.size() + pe_cyc.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop1_busy_idle got %b want 0", busy); end
        stop_bits = 1'b0;
    endtask

    task automatic test_spike();
        int c1;
        prescale = 6'd16; par_en = 1'b0; stop_bits = 1'b0;
        clear_log();
        send_frame(16, 8'hFF, 0, 0, 1, 0, 1, 3, c1);
        wait_cyc(8);
        n_vec++; if (((dv_cyc.size() == 1) ? dv_cyc[0] : -1) !== c1 + 155) begin n_err++; $display("FAIL spike_dv_cycle got %0d want %0d", (dv_cyc.size() == 1) ? dv_cyc[0] : -1, c1 + 155); end
        n_vec++; if (p_data !== 8'hFF) begin n_err++; $display("FAIL spike_p_data got %h want ff", p_data); end
        n_vec++; if (pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL spike_err_pulses got %0d want 0", pe_cyc.size() + se_cyc.size()); end
    endtask

    task automatic test_prescale_change();
        int c1;
        prescale = 6'd8; par_en = 1'b0; stop_bits = 1'b0;
        clear_log();
        fork
            send_frame(8, 8'hC3, 0, 0, 1, 0, 1, -1, c1);
            begin
                wait_cyc(30);
                prescale = 6'd16; par_en = 1'b1; stop_bits = 1'b1;
            end
        join
        wait_cyc(8);
        n_vec++; if (((dv_cyc.size() == 1) ? dv_cyc[0] : -1) !== c1 + 79) begin n_err++; $display("FAIL cfg_hold_dv_cycle got %0d want %0d", (dv_cyc.size() == 1) ? dv_cyc[0] : -1, c1 + 79); end
        n_vec++; if (p_data !== 8'hC3) begin n_err++; $display("FAIL cfg_hold_p_data got %h want c3", p_data); end
        n_vec++; if (pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL cfg_hold_err_pulses got %0d want 0", pe_cyc.size() + se_cyc.size()); end
        prescale = 6'd8; par_en = 1'b0; stop_bits = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c1;
        prescale = 6'd8;
        clear_log();
        rx_in = 1'b0;
        wait_cyc(28);
        rst = 1'b0;
        rx_in = 1'b1;
        wait_cyc(1);
        n_vec++; if (p_data !== 8'h00) begin n_err++; $display("FAIL rstmid_p_data got %h want 00", p_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(10);
        n_vec++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin n_err++; $display("FAIL rstmid_pulses got %0d want 0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
        send_frame(8, 8'h5A, 0, 0, 1, 0, 1, -1, c1);
        wait_cyc(8);
        n_vec++; if (((dv_cyc.size() == 1) ? dv_cyc[0] : -1) !== c1 + 79) begin n_err++; $display("FAIL rstmid_next_dv_cycle got %0d want %0d", (dv_cyc.size() == 1) ? dv_cyc[0] : -1, c1 + 79); end
        n_vec++; if (p_data !== 8'h5A) begin n_err++; $display("FAIL rstmid_next_p_data got %h want 5a", p_data); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_stop();
        test_spike();
        test_prescale_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_core_param.md
Name: uart_rx_core_param

Overview:
- Parametrised UART receive core: control FSM, edge/bit counters, 3-sample majority sampler, deserialiser and parity/stop checking in one block.
- Next-generation successor to the fixed 8-bit RX control FSM. Adds configurable data width, odd/even parity select, 1 or 2 stop bits, and majority-vote sampling.
- Adds frame-aligned error recovery: a parity error does not abort the frame.
- Sits between the RX clock-domain input synchroniser and the RX data consumer. rx_in arrives already synchronised to clk.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9; transmitted LSB first.
PRESCALE_W, 6, width of the prescale input; edge counter is this wide.

Ports:
clk  input  1  RX oversampling clock.
rst  input  1  asynchronous active-low reset.
rx_in  input  1  serial line, synchronous to clk, idle high.
prescale  input  PRESCALE_W  oversampling ratio (clk cycles per bit).
par_en  input  1  1 = parity bit present.
par_typ  input  1  0 = even parity, 1 = odd parity.
stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
p_data  output  DATA_WIDTH  last good received word.
data_valid  output  1  one-cycle pulse: p_data updated with an error-free frame.
par_err  output  1  one-cycle pulse at frame completion: parity mismatch.
stp_err  output  1  one-cycle pulse at frame completion: stop bit sampled 0.
busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset: all outputs 0, including p_data. FSM in IDLE, counters and shift register 0. Reset mid-frame discards the frame with no pulses; the next frame is received normally after rst deasserts.
- Configuration latch:
  - prescale, par_en, par_typ and stop_bits are captured on the IDLE->START transition and held for the whole frame.
  - Changes mid-frame are ignored.
  - Effective prescale P: LSB forced to 0; values below 8 treated as 8.
- Edge counter:
  - Counts 0..P-1 per bit, then wraps to 0 and advances the bit index.
  - The IDLE cycle in which rx_in==0 is detected is edge 0 of the start bit.
  - Let M = P/2. Samples are taken at edges M-1, M and M+1. The bit value is the majority of the 3 samples.
  - The decision point is edge M+2. All checks, shifts and transitions based on bit value happen there.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: rx_in==0 -> START.
  - START:
    - At the decision point, majority 1 = glitch -> IDLE, no output pulses.
    - Otherwise, at edge P-1 -> DATA, bit index 0.
  - DATA:
    - Majority bit shifted in LSB-first at the decision point.
    - After bit DATA_WIDTH-1, at edge P-1 -> PARITY if par_en, else STOP1.
  - PARITY:
    - Expected bit = XOR of data bits, inverted when par_typ=1.
    - A mismatch sets an internal par_fail flag. The FSM continues to STOP1 (no abort).
  - STOP1:
    - At the decision point, majority 0 sets stp_fail and completes the frame immediately.
    - Else, if stop_bits=1, -> STOP2 at edge P-1.
    - Else the frame completes at this decision point.
  - STOP2: at the decision point, majority 0 sets stp_fail. The frame completes either way.
- Frame completion (cycle N = final decision point):
  - FSM goes to IDLE at N+1.
  - In cycle N+1, exactly one of these occurs:
    - data_valid=1 and p_data=shift register, when neither fail flag is set; or
    - par_err and/or stp_err =1 for one cycle, with p_data unchanged.
  - Fail flags are cleared at completion.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after completion. No extra idle bit is required.
- busy is registered: high from the cycle after start detection through the completion cycle N; low at N+1.

Test Plan:
1. P=8, 8N1, frame 0xA5, two frames back-to-back -> data_valid pulses twice, each exactly 1 cycle after the stop decision; p_data=0xA5; no error pulses.
2. P=16, par_en=1, par_typ=0, data 0x3C, parity bit driven 1 (wrong) -> par_err pulse; no data_valid; p_data keeps its previous value. The next correct frame 0x81 is received with data_valid.
3. P=8, rx_in low for only 2 cycles then high -> FSM returns to IDLE at the start decision point; busy drops; no data_valid/par_err/stp_err.
4. P=8, stop_bits=1, data 0x55, second stop bit driven 0 -> stp_err pulse only. Same stimulus with the first stop bit 0 -> stp_err at the STOP1 decision point, STOP2 never entered.
5. P=16, 1-cycle low spike at edge M of a data bit whose value is 1 -> majority keeps bit=1. Frame 0xFF delivered with data_valid.
6. prescale changed 8->16 during the DATA state -> current frame still decoded at 8. rst pulsed low mid-frame -> all outputs 0, no pulses, next frame decoded correctly.
